// File: rtl/riscv_test_monitor_pkg.sv
// Shared encodings and defaults for the RV32I end-of-test monitor.
// The state values are visible to benches and LEDs, so they are fixed and must not change.
package riscv_test_monitor_pkg;

   localparam int          MON_STATE_BIT   = 3;
   localparam logic [31:0] DEF_TOHOST_ADDR = 32'd100;
   localparam logic [31:0] DEF_PASS_VALUE  = 32'd25;

   typedef enum logic [MON_STATE_BIT-1:0] {
      MON_IDLE    = 3'd0,
      MON_RUN     = 3'd1,
      MON_PASS    = 3'd2,
      MON_FAIL    = 3'd3,
      MON_TIMEOUT = 3'd4,
      MON_HANG    = 3'd5
   } mon_state_e;

   function automatic logic is_terminal(input mon_state_e s);
      return (s == MON_PASS) || (s == MON_FAIL) || (s == MON_TIMEOUT) || (s == MON_HANG);
   endfunction

endpackage

// File: rtl/riscv_test_monitor_if.sv
// Core-tap and verdict signals of the end-of-test monitor.
// The master side drives the core taps and reads the verdict; the slave side is the monitor.
interface riscv_test_monitor_if #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 32
);
   logic             i_enable;
   logic [XLEN-1:0]  i_pc;
   logic             i_dmem_wr_en;
   logic [XLEN-1:0]  i_dmem_addr;
   logic [3:0]       i_dmem_byte_sel;
   logic [XLEN-1:0]  i_dmem_wr_data;
   logic [2:0]       o_state;
   logic             o_done;
   logic             o_pass;
   logic [XLEN-1:0]  o_result;
   logic [CNT_W-1:0] o_cycle_cnt;
   logic [CNT_W-1:0] o_store_cnt;

   modport master (
      output i_enable, i_pc, i_dmem_wr_en, i_dmem_addr, i_dmem_byte_sel, i_dmem_wr_data,
      input  o_state, o_done, o_pass, o_result, o_cycle_cnt, o_store_cnt
   );

   modport slave (
      input  i_enable, i_pc, i_dmem_wr_en, i_dmem_addr, i_dmem_byte_sel, i_dmem_wr_data,
      output o_state, o_done, o_pass, o_result, o_cycle_cnt, o_store_cnt
   );
endinterface

// File: rtl/riscv_test_monitor_stall.sv
// PC stall detector: counts consecutive edges where the fetch PC is unchanged.
// Latency: hang is combinational on the edge the count reaches STALL_LIMIT; no backpressure.
module riscv_pc_stall_detector #(
   parameter int XLEN        = 32,
   parameter int STALL_LIMIT = 4
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            clr,
   input  logic            en,
   input  logic [XLEN-1:0] pc,
   output logic            hang
);
   localparam int CW = (STALL_LIMIT > 0) ? $clog2(STALL_LIMIT + 1) : 1;

   logic [XLEN-1:0] prev_pc;
   logic [CW-1:0]   stall_cnt;
   logic            same_pc;

   assign same_pc = (pc == prev_pc);

   // clr marks the run-start edge: it seeds prev_pc without counting a stall
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         prev_pc   <= '0;
         stall_cnt <= '0;
      end else if (clr) begin
         prev_pc   <= pc;
         stall_cnt <= '0;
      end else if (en) begin
         prev_pc   <= pc;
         stall_cnt <= same_pc ? stall_cnt + CW'(1) : '0;
      end
   end

   assign hang = (STALL_LIMIT != 0) && en && same_pc && (stall_cnt == CW'(STALL_LIMIT - 1));

endmodule

// File: rtl/riscv_test_monitor.sv
// End-of-test monitor: watches PC and dmem stores, latches pass/fail/timeout/hang verdict.
// Latency: verdict visible one edge after the deciding store or cycle; observes only, never stalls the core.
module riscv_test_monitor
   import riscv_test_monitor_pkg::*;
#(
   parameter int              XLEN        = 32,
   parameter int              CNT_W       = 32,
   parameter int              MAX_CYCLES  = 200,
   parameter logic [XLEN-1:0] TOHOST_ADDR = DEF_TOHOST_ADDR,
   parameter logic [XLEN-1:0] PASS_VALUE  = DEF_PASS_VALUE,
   parameter int              STALL_LIMIT = 4
) (
   input  logic                 i_clk,
   input  logic                 i_rstn,
   riscv_test_monitor_if.slave  mon
);

`ifdef DEBUG
   if (MAX_CYCLES < 1 || (CNT_W < 32 && MAX_CYCLES >= (1 << CNT_W))) begin : g_param_check
      $error("riscv_test_monitor: MAX_CYCLES must be in [1, 2**CNT_W)");
   end
`endif

   mon_state_e       state_q, state_d;
   logic [CNT_W-1:0] cycle_q, store_q;
   logic [XLEN-1:0]  result_q;
   logic             start, running, hit, timeout, hang;

   assign start   = (state_q == MON_IDLE) && mon.i_enable;
   assign running = (state_q == MON_RUN) && mon.i_enable;
   assign hit     = mon.i_dmem_wr_en && (mon.i_dmem_addr == TOHOST_ADDR) &&
                    (mon.i_dmem_byte_sel == 4'hF);
   assign timeout = (cycle_q == CNT_W'(MAX_CYCLES - 1));

   riscv_pc_stall_detector #(
      .XLEN        (XLEN),
      .STALL_LIMIT (STALL_LIMIT)
   ) u_stall (
      .clk  (i_clk),
      .rstn (i_rstn),
      .clr  (start),
      .en   (running),
      .pc   (mon.i_pc),
      .hang (hang)
   );

   // A tohost write outranks timeout, which outranks hang, on the same edge
   always_comb begin
      state_d = state_q;
      case (state_q)
         MON_IDLE: if (mon.i_enable) state_d = MON_RUN;
         MON_RUN: begin
            if (running) begin
               if (hit)          state_d = (mon.i_dmem_wr_data == PASS_VALUE) ? MON_PASS : MON_FAIL;
               else if (timeout) state_d = MON_TIMEOUT;
               else if (hang)    state_d = MON_HANG;
            end
         end
         default: state_d = state_q;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) state_q <= MON_IDLE;
      else         state_q <= state_d;
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         cycle_q  <= '0;
         store_q  <= '0;
         result_q <= '0;
      end else if (running) begin
         cycle_q <= cycle_q + CNT_W'(1);
         if (mon.i_dmem_wr_en) store_q  <= store_q + CNT_W'(1);
         if (hit)              result_q <= mon.i_dmem_wr_data;
      end
   end

   assign mon.o_state     = state_q;
   assign mon.o_done      = is_terminal(state_q);
   assign mon.o_pass      = (state_q == MON_PASS);
   assign mon.o_result    = result_q;
   assign mon.o_cycle_cnt = cycle_q;
   assign mon.o_store_cnt = store_q;

endmodule

// File: tb/tb_riscv_test_monitor.sv
// Bench for riscv_test_monitor: two parameterisations share one stimulus trace, a trace-level
// model predicts each verdict, and a negedge monitor pops the prediction when o_done rises.
module tb_riscv_test_monitor;

   typedef struct {
      logic        en;
      logic [31:0] pc;
      logic        wr;
      logic [31:0] addr;
      logic [3:0]  sel;
      logic [31:0] data;
   } cyc_t;

   typedef struct {
      logic [2:0]  state;
      logic [31:0] result;
      logic [31:0] cycles;
      logic [31:0] stores;
      int          idx;
      int          edge_no;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   edge_no = 0;
   int   checks = 0;
   int   fails = 0;

   cyc_t tr[$];
   exp_t exp_a[$];
   exp_t exp_b[$];
   exp_t cur[2];
   bit   active[2];
   bit   prev_done[2];

   riscv_test_monitor_if #(.XLEN(32), .CNT_W(32)) ifa ();
   riscv_test_monitor_if #(.XLEN(32), .CNT_W(32)) ifb ();

   riscv_test_monitor #(.XLEN(32), .CNT_W(32), .MAX_CYCLES(50), .TOHOST_ADDR(32'd100),
                        .PASS_VALUE(32'd25), .STALL_LIMIT(4))
      dut_a (.i_clk(clk), .i_rstn(rst_n), .mon(ifa));

   riscv_test_monitor #(.XLEN(32), .CNT_W(32), .MAX_CYCLES(20), .TOHOST_ADDR(32'd100),
                        .PASS_VALUE(32'd25), .STALL_LIMIT(0))
      dut_b (.i_clk(clk), .i_rstn(rst_n), .mon(ifb));

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      edge_no++;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: run not finished, got time %0t required below 1000000", $time);
      $fatal(1);
   end

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d required %0d", name, act, exp);
      end
   endtask

   task automatic add(input logic en, input logic [31:0] pc, input logic wr,
                      input logic [31:0] addr, input logic [3:0] sel, input logic [31:0] data);
      cyc_t c;
      c.en = en; c.pc = pc; c.wr = wr; c.addr = addr; c.sel = sel; c.data = data;
      tr.push_back(c);
   endtask

   // Long run of fresh PCs guarantees a timeout, then junk that a terminated monitor must ignore
   task automatic add_tail_and_junk();
      for (int i = 0; i < 60; i++) add(1'b1, 32'h1000 + 32'(4 * i), 1'b0, 32'd0, 4'h0, 32'd0);
      for (int i = 0; i < 20; i++)
         add(1'($urandom % 2), $urandom, 1'b1, 32'd100, 4'hF, ($urandom % 2) ? 32'd25 : 32'd7);
   endtask

   task automatic build_directed(input int kind);
      tr.delete();
      case (kind)
         0, 1: for (int i = 0; i <= 30; i++)
                  add(1'b1, 32'(4 * i), (i == 30) || (kind == 1 && i == 10), 32'd100,
                      (i == 10) ? 4'h1 : 4'hF, (kind == 1) ? 32'd7 : 32'd25);
         2:    for (int i = 0; i < 70; i++) add(1'b1, 32'(4 * i), 1'b0, 32'd0, 4'h0, 32'd0);
         3:    for (int i = 0; i < 30; i++)
                  add(1'b1, (i < 12) ? 32'(4 * i) : 32'h40, 1'b0, 32'd0, 4'h0, 32'd0);
         4:    for (int i = 0; i <= 20; i++) add(1'b1, 32'(4 * i), i == 20, 32'd100, 4'hF, 32'd25);
         default: for (int i = 0; i < 40; i++)
                  add(!(i >= 8 && i < 13), 32'(4 * i), 1'b0, 32'd0, 4'h0, 32'd0);
      endcase
      add_tail_and_junk();
   endtask

   task automatic build_random();
      int n = $urandom_range(20, 60);
      int hold = 0;
      logic [31:0] pc = 32'd0;
      tr.delete();
      for (int i = 0; i < n; i++) begin
         if (hold > 0) hold--;
         else if ($urandom % 8 == 0) hold = $urandom_range(1, 6);
         else pc = pc + 32'd4;
         add(($urandom % 8) != 0, pc, ($urandom % 5) == 0,
             ($urandom % 3 == 0) ? 32'd100 : 32'(4 * $urandom_range(0, 63)),
             ($urandom % 2) ? 4'hF : 4'($urandom_range(0, 15)),
             ($urandom % 2) ? 32'd25 : 32'($urandom_range(0, 40)));
      end
      add_tail_and_junk();
   endtask

   // Walks the trace edge by edge applying the monitor's rules directly
   function automatic exp_t model(input int max_c, input int stall_lim);
      exp_t e;
      bit started = 0;
      int run_len = 0;
      logic [31:0] prev = 32'd0;
      e.state = 3'd0; e.result = 0; e.cycles = 0; e.stores = 0; e.idx = -1; e.edge_no = 0;
      for (int k = 0; k < tr.size(); k++) begin
         if (!tr[k].en) continue;
         if (!started) begin
            started = 1; prev = tr[k].pc; run_len = 0; e.state = 3'd1;
            continue;
         end
         e.cycles++;
         if (tr[k].wr) e.stores++;
         run_len = (tr[k].pc == prev) ? run_len + 1 : 0;
         prev = tr[k].pc;
         e.idx = k;
         if (tr[k].wr && tr[k].addr == 32'd100 && tr[k].sel == 4'hF) begin
            e.result = tr[k].data;
            e.state = (tr[k].data == 32'd25) ? 3'd2 : 3'd3;
            return e;
         end
         if (e.cycles == 32'(max_c)) begin e.state = 3'd4; return e; end
         if (stall_lim != 0 && run_len == stall_lim) begin e.state = 3'd5; return e; end
      end
      e.idx = -1;
      return e;
   endfunction

   task automatic set_in(input cyc_t c);
      ifa.i_enable = c.en; ifa.i_pc = c.pc; ifa.i_dmem_wr_en = c.wr;
      ifa.i_dmem_addr = c.addr; ifa.i_dmem_byte_sel = c.sel; ifa.i_dmem_wr_data = c.data;
      ifb.i_enable = c.en; ifb.i_pc = c.pc; ifb.i_dmem_wr_en = c.wr;
      ifb.i_dmem_addr = c.addr; ifb.i_dmem_byte_sel = c.sel; ifb.i_dmem_wr_data = c.data;
   endtask

   task automatic check_reset();
      check("rst_a state",  ifa.o_state, 0);      check("rst_b state",  ifb.o_state, 0);
      check("rst_a done",   ifa.o_done, 0);       check("rst_b done",   ifb.o_done, 0);
      check("rst_a pass",   ifa.o_pass, 0);       check("rst_b pass",   ifb.o_pass, 0);
      check("rst_a result", ifa.o_result, 0);     check("rst_b result", ifb.o_result, 0);
      check("rst_a cycles", ifa.o_cycle_cnt, 0);  check("rst_b cycles", ifb.o_cycle_cnt, 0);
      check("rst_a stores", ifa.o_store_cnt, 0);  check("rst_b stores", ifb.o_store_cnt, 0);
   endtask

   task automatic run_scenario(input int abort_at);
      exp_t ea, eb;
      cyc_t idle_c;
      int n;
      idle_c.en = 0; idle_c.pc = 0; idle_c.wr = 0; idle_c.addr = 0; idle_c.sel = 0; idle_c.data = 0;
      @(posedge clk); #1;
      n = tr.size();
      if (abort_at < 0) begin
         ea = model(50, 4);
         eb = model(20, 0);
         ea.edge_no = edge_no + ea.idx + 1;
         eb.edge_no = edge_no + eb.idx + 1;
         exp_a.push_back(ea);
         exp_b.push_back(eb);
      end else n = abort_at;
      for (int k = 0; k < n; k++) begin
         set_in(tr[k]);
         @(posedge clk); #1;
      end
      check("pending_a", exp_a.size(), 0);
      check("pending_b", exp_b.size(), 0);
      exp_a.delete(); exp_b.delete();
      set_in(idle_c);
      rst_n = 1'b0;
      #1;
      check_reset();
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic mon_step(input int d, input logic [2:0] st, input logic dn, input logic ps,
                           input logic [31:0] res, input logic [31:0] cy, input logic [31:0] so);
      exp_t e;
      bit empty = (d == 0) ? (exp_a.size() == 0) : (exp_b.size() == 0);
      if (dn && !prev_done[d]) begin
         if (empty) begin
            checks++; fails++;
            $display("FAIL dut%0d unexpected_done: got state %0d required no verdict", d, st);
            active[d] = 0;
         end else begin
            if (d == 0) e = exp_a.pop_front();
            else        e = exp_b.pop_front();
            cur[d] = e; active[d] = 1;
            check($sformatf("dut%0d term_edge", d), edge_no, e.edge_no);
            check($sformatf("dut%0d state", d), st, e.state);
            check($sformatf("dut%0d pass", d), ps, e.state == 3'd2);
            check($sformatf("dut%0d result", d), res, e.result);
            check($sformatf("dut%0d cycles", d), cy, e.cycles);
            check($sformatf("dut%0d stores", d), so, e.stores);
         end
      end else if (dn && active[d]) begin
         e = cur[d];
         check($sformatf("dut%0d frozen_state", d), st, e.state);
         check($sformatf("dut%0d frozen_result", d), res, e.result);
         check($sformatf("dut%0d frozen_cycles", d), cy, e.cycles);
         check($sformatf("dut%0d frozen_stores", d), so, e.stores);
      end
      prev_done[d] = dn;
      if (!dn) active[d] = 0;
   endtask

   initial forever begin
      @(negedge clk);
      if (!rst_n) begin
         prev_done[0] = 0; prev_done[1] = 0; active[0] = 0; active[1] = 0;
      end else begin
         mon_step(0, ifa.o_state, ifa.o_done, ifa.o_pass, ifa.o_result, ifa.o_cycle_cnt, ifa.o_store_cnt);
         mon_step(1, ifb.o_state, ifb.o_done, ifb.o_pass, ifb.o_result, ifb.o_cycle_cnt, ifb.o_store_cnt);
      end
   end

   initial begin
      cyc_t z;
      z.en = 0; z.pc = 0; z.wr = 0; z.addr = 0; z.sel = 0; z.data = 0;
      set_in(z);
      #3;
      check_reset();
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int kind = 0; kind < 6; kind++) begin
         build_directed(kind);
         run_scenario(-1);
      end
      build_directed(0);
      run_scenario(15);
      build_directed(0);
      run_scenario(-1);
      for (int r = 0; r < 24; r++) begin
         build_random();
         run_scenario(-1);
      end
      $display("[TB] %0d tests run, %0d failed", checks, fails);
      $finish;
   end

endmodule
